// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer blitter.
package fb_pkg;

  localparam int unsigned FB_W      = 240;
  localparam int unsigned FB_H      = 160;
  localparam int unsigned FB_ADDR_W = 19;

  typedef enum logic [1:0] {IDLE, DRAW_MAP, DRAW_CHAR, FINISH} blit_state_t;

  typedef logic [23:0]          pixel_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  localparam logic [1:0] DIR_DOWN  = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  function automatic fb_addr_t fb_index(input logic [8:0] x, input logic [8:0] y);
    return fb_addr_t'(y) * fb_addr_t'(FB_W) + fb_addr_t'(x);
  endfunction

endpackage

// File: rtl/fb_blitter_if.sv
// Memory-side bus of the blitter: map ROM, sprite ROM and framebuffer write port.
interface fb_blitter_if;
  import fb_pkg::*;

  logic [18:0] mapAddr;
  pixel_t      mapData;
  logic [9:0]  sprAddr;
  pixel_t      sprData;
  fb_addr_t    FBwrite_address;
  pixel_t      FBdata_In;
  logic        FBwe;

  modport master (
    output mapAddr, sprAddr, FBwrite_address, FBdata_In, FBwe,
    input  mapData, sprData
  );

  modport slave (
    input  mapAddr, sprAddr, FBwrite_address, FBdata_In, FBwe,
    output mapData, sprData
  );

endinterface

// File: rtl/fb_write_pipe.sv
// Aligns read requests with ROM data, applies key/clip suppression and registers the framebuffer write.
// FB_BLITTER_FADE_EN inserts a fade stage between suppression and the output register.
module fb_write_pipe
  import fb_pkg::*;
#(
  parameter pixel_t KEY_COLOR = 24'hFF00FF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       req_valid,
  input  logic       req_spr,
  input  logic [8:0] req_x,
  input  logic [8:0] req_y,
  input  pixel_t     map_data,
  input  pixel_t     spr_data,
`ifdef FB_BLITTER_FADE_EN
  input  logic [3:0] fade,
`endif
  output logic       pending,
  output logic       we,
  output fb_addr_t   addr,
  output pixel_t     data
);
  logic       s2_valid, s2_spr;
  logic [8:0] s2_x, s2_y;
  pixel_t     s2_pix;
  logic       s2_we;
  fb_addr_t   s2_addr;

  // ROM data arrives one cycle after the request; the key test uses raw sprite data.
  always_comb begin
    s2_pix  = s2_spr ? spr_data : map_data;
    s2_we   = s2_valid && !(s2_spr && (spr_data == KEY_COLOR ||
                                       s2_x > 9'(FB_W - 1) || s2_y > 9'(FB_H - 1)));
    s2_addr = fb_index(s2_x, s2_y);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      s2_valid <= 1'b0;
      s2_spr   <= 1'b0;
      s2_x     <= '0;
      s2_y     <= '0;
    end else begin
      s2_valid <= req_valid;
      s2_spr   <= req_spr;
      s2_x     <= req_x;
      s2_y     <= req_y;
    end
  end

`ifdef FB_BLITTER_FADE_EN
  logic     f_valid, f_we;
  fb_addr_t f_addr;
  pixel_t   f_pix;

  function automatic logic [7:0] fade_ch(input logic [7:0] c, input logic [3:0] f);
    logic [11:0] p;
    p = {4'b0, c} * {8'b0, 4'd15 - f};
    return p[11:4];
  endfunction

  assign pending = s2_valid | f_valid;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      f_valid <= 1'b0;
      f_we    <= 1'b0;
      f_addr  <= '0;
      f_pix   <= '0;
      we      <= 1'b0;
      addr    <= '0;
      data    <= '0;
    end else begin
      f_valid <= s2_valid;
      f_we    <= s2_we;
      f_addr  <= s2_addr;
      f_pix   <= s2_pix;
      we      <= f_we;
      if (f_we) begin
        addr <= f_addr;
        data <= {fade_ch(f_pix[23:16], fade), fade_ch(f_pix[15:8], fade), fade_ch(f_pix[7:0], fade)};
      end
    end
  end
`else
  assign pending = s2_valid;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      we   <= 1'b0;
      addr <= '0;
      data <= '0;
    end else begin
      we <= s2_we;
      if (s2_we) begin
        addr <= s2_addr;
        data <= s2_pix;
      end
    end
  end
`endif

endmodule

// File: rtl/fb_blitter.sv
// Frame composer: copies a clamped camera window of the world map into the framebuffer, then overlays
// the colour-keyed player sprite. FB_BLITTER_FADE_EN adds a fade[3:0] input latched at start.
module fb_blitter
  import fb_pkg::*;
#(
  parameter int unsigned MAP_W     = 480,
  parameter int unsigned MAP_H     = 320,
  parameter pixel_t      KEY_COLOR = 24'hFF00FF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic [8:0] camX,
  input  logic [8:0] camY,
  input  logic [7:0] playerX,
  input  logic [7:0] playerY,
  input  logic [1:0] playerDir,
`ifdef FB_BLITTER_FADE_EN
  input  logic [3:0] fade,
`endif
  output logic       busy,
  output logic       done,
  fb_blitter_if.master bus
);
  localparam logic [8:0] CAM_X_MAX = 9'(MAP_W - FB_W);
  localparam logic [8:0] CAM_Y_MAX = 9'(MAP_H - FB_H);
  localparam logic [7:0] X_LAST    = 8'(FB_W - 1);
  localparam logic [7:0] Y_LAST    = 8'(FB_H - 1);

  blit_state_t state, state_n;
  logic [7:0]  x, y;
  logic [8:0]  cam_x, cam_y;
  logic [7:0]  pl_x, pl_y;
  logic [1:0]  pl_dir;
  logic [18:0] map_addr;
  logic [9:0]  spr_addr;
  logic        req_valid, req_spr;
  logic [8:0]  req_x, req_y;
  logic        pipe_pending, last_map, last_spr;
  logic        fb_we;
  fb_addr_t    fb_addr;
  pixel_t      fb_data;

  assign last_map            = (x == X_LAST) && (y == Y_LAST);
  assign last_spr            = (x[3:0] == 4'hF) && (y[3:0] == 4'hF);
  assign busy                = (state != IDLE);
  assign bus.mapAddr         = map_addr;
  assign bus.sprAddr         = spr_addr;
  assign bus.FBwe            = fb_we;
  assign bus.FBwrite_address = fb_addr;
  assign bus.FBdata_In       = fb_data;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (start) state_n = DRAW_MAP;
      DRAW_MAP:  if (last_map) state_n = DRAW_CHAR;
      DRAW_CHAR: if (last_spr) state_n = FINISH;
      FINISH:    if (!req_valid && !pipe_pending) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Read addresses are registered, so a read is "issued" in the cycle after its counter value.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      cam_x     <= '0;
      cam_y     <= '0;
      pl_x      <= '0;
      pl_y      <= '0;
      pl_dir    <= '0;
      map_addr  <= '0;
      spr_addr  <= '0;
      req_valid <= 1'b0;
      req_spr   <= 1'b0;
      req_x     <= '0;
      req_y     <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      done      <= (state == FINISH) && (state_n == IDLE);
      req_valid <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          cam_x  <= (camX > CAM_X_MAX) ? CAM_X_MAX : camX;
          cam_y  <= (camY > CAM_Y_MAX) ? CAM_Y_MAX : camY;
          pl_x   <= playerX;
          pl_y   <= playerY;
          pl_dir <= playerDir;
          x      <= '0;
          y      <= '0;
        end
        DRAW_MAP: begin
          map_addr  <= (19'(cam_y) + 19'(y)) * 19'(MAP_W) + 19'(cam_x) + 19'(x);
          req_valid <= 1'b1;
          req_spr   <= 1'b0;
          req_x     <= {1'b0, x};
          req_y     <= {1'b0, y};
          if (x == X_LAST) begin
            x <= '0;
            y <= last_map ? '0 : y + 8'd1;
          end else begin
            x <= x + 8'd1;
          end
        end
        DRAW_CHAR: begin
          spr_addr  <= {pl_dir, y[3:0], x[3:0]};
          req_valid <= 1'b1;
          req_spr   <= 1'b1;
          req_x     <= {1'b0, pl_x} + {5'b0, x[3:0]};
          req_y     <= {1'b0, pl_y} + {5'b0, y[3:0]};
          if (x[3:0] == 4'hF) begin
            x <= '0;
            y <= y + 8'd1;
          end else begin
            x <= x + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FB_BLITTER_FADE_EN
  logic [3:0] fade_q;

  always_ff @(posedge Clk) begin
    if (!Reset)                      fade_q <= '0;
    else if (state == IDLE && start) fade_q <= fade;
  end
`endif

  fb_write_pipe #(.KEY_COLOR(KEY_COLOR)) u_pipe (
    .Clk      (Clk),
    .Reset    (Reset),
    .req_valid(req_valid),
    .req_spr  (req_spr),
    .req_x    (req_x),
    .req_y    (req_y),
    .map_data (bus.mapData),
    .spr_data (bus.sprData),
`ifdef FB_BLITTER_FADE_EN
    .fade     (fade_q),
`endif
    .pending  (pipe_pending),
    .we       (fb_we),
    .addr     (fb_addr),
    .data     (fb_data)
  );

endmodule

// File: tb/tb_fb_blitter.sv
// Bench for fb_blitter: random map/sprite content checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_fb_blitter;
  import fb_pkg::*;

  localparam pixel_t KEY  = 24'hFF00FF;
  localparam int     NPIX = 38400;
`ifdef FB_BLITTER_FADE_EN
  localparam bit     FADE_ON   = 1'b1;
  localparam int     LAT       = 38660;
  localparam int     R_WRITES  = 996;
  localparam pixel_t EXP_WHITE = 24'h6F6F6F;
`else
  localparam bit     FADE_ON   = 1'b0;
  localparam int     LAT       = 38659;
  localparam int     R_WRITES  = 997;
  localparam pixel_t EXP_WHITE = 24'hFFFFFF;
`endif

  logic       clk = 1'b0;
  logic       Reset, start, busy, done;
  logic [8:0] camX, camY;
  logic [7:0] playerX, playerY;
  logic [1:0] playerDir;
  logic [3:0] fade_lvl;

  fb_blitter_if bus ();

  fb_blitter #(.MAP_W(480), .MAP_H(320), .KEY_COLOR(KEY)) dut (
    .Clk(clk), .Reset(Reset), .start(start), .camX(camX), .camY(camY),
    .playerX(playerX), .playerY(playerY), .playerDir(playerDir),
`ifdef FB_BLITTER_FADE_EN
    .fade(fade_lvl),
`endif
    .busy(busy), .done(done), .bus(bus));

  always #5 clk = ~clk;

  // ROM models, 1-cycle read latency
  pixel_t spr_rom [1024];
  pixel_t salt;
  always @(posedge clk) begin
    bus.mapData <= 24'(bus.mapAddr) ^ salt;
    bus.sprData <= spr_rom[bus.sprAddr];
  end

  // Framebuffer model fed from the write port
  pixel_t      fb_mem [NPIX];
  int          wr_count = 0, oob_count = 0, spr_mark = -1;
  logic [18:0] first_spr_addr;
  pixel_t      first_spr_data;
  always @(negedge clk) begin
    if (bus.FBwe === 1'b1) begin
      if (wr_count == spr_mark) begin
        first_spr_addr = bus.FBwrite_address;
        first_spr_data = bus.FBdata_In;
      end
      if (int'(bus.FBwrite_address) < NPIX) fb_mem[bus.FBwrite_address] = bus.FBdata_In;
      else oob_count++;
      wr_count++;
    end
  end

  int     tests = 0, failed = 0;
  pixel_t exp_fb [NPIX];
  int     exp_spr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic pixel_t fadepix(input pixel_t p, input logic [3:0] f);
    pixel_t r;
    for (int i = 0; i < 3; i++) r[8*i +: 8] = 8'((int'(p[8*i +: 8]) * (15 - int'(f))) / 16);
    return FADE_ON ? r : p;
  endfunction

  function automatic pixel_t rnd_pix();
    pixel_t v;
    v = pixel_t'($urandom);
    if (v == KEY) v = v ^ 24'h1;
    return v;
  endfunction

  task automatic fill_sprites(input int key_pct);
    for (int i = 0; i < 1024; i++)
      spr_rom[i] = (int'($urandom_range(0, 99)) < key_pct) ? KEY : rnd_pix();
  endtask

  // Reference frame: clamped window of the map, then visible non-key sprite pixels on top.
  task automatic build_expected(input int cx, cy, px, py, dir, input logic [3:0] f);
    int ox, oy, tx, ty;
    pixel_t p;
    ox = (cx > 240) ? 240 : cx;
    oy = (cy > 160) ? 160 : cy;
    for (int yy = 0; yy < 160; yy++)
      for (int xx = 0; xx < 240; xx++)
        exp_fb[yy*240 + xx] = fadepix(24'((oy + yy)*480 + ox + xx) ^ salt, f);
    exp_spr = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        tx = px + c;
        ty = py + r;
        p  = spr_rom[dir*256 + r*16 + c];
        if (p != KEY && tx < 240 && ty < 160) begin
          exp_fb[ty*240 + tx] = fadepix(p, f);
          exp_spr++;
        end
      end
  endtask

  task automatic check_frame(input string tag, input int upto);
    int bad = 0;
    for (int a = 0; a < upto; a++) if (fb_mem[a] !== exp_fb[a]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic run_frame(input string tag, input bit mid_start, output int cycles);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    cycles = 0;
    while (cycles < 45000) begin
      @(posedge clk); #1;
      cycles++;
      start = 1'b0;
      if (mid_start && cycles == 500) begin
        start     = 1'b1;
        camX      = 9'($urandom);
        camY      = 9'($urandom);
        playerX   = 8'($urandom);
        playerY   = 8'($urandom);
        playerDir = 2'($urandom);
        fade_lvl  = 4'($urandom);
      end
      if (done === 1'b1) break;
    end
    start = 1'b0;
    check({tag, "_done_latency"}, cycles, LAT);
    check({tag, "_busy_at_done"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    int cyc, base, snap;
    int s_px, s_py, s_dir;
    Reset = 1'b0; start = 1'b0; camX = '0; camY = '0;
    playerX = '0; playerY = '0; playerDir = '0; fade_lvl = '0;
    salt = pixel_t'($urandom);
    fill_sprites(25);
    repeat (3) @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", bus.FBwe, 0);
    check("rst_fb_addr", bus.FBwrite_address, 0);
    check("rst_fb_data", bus.FBdata_In, 0);
    check("rst_map_addr", bus.mapAddr, 0);
    check("rst_spr_addr", bus.sprAddr, 0);
    Reset = 1'b1;
    @(posedge clk); #1;

    // Frame A: clamped camera, checkerboard left-facing sprite, ignored mid-frame start
    fill_sprites(0);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        spr_rom[512 + r*16 + c] = ((r + c) % 2 == 0) ? rnd_pix() : KEY;
    spr_rom[512] = 24'hFFFFFF;
    salt = pixel_t'($urandom);
    camX = 9'd400; camY = 9'd300; playerX = 8'd10; playerY = 8'd20; playerDir = DIR_LEFT; fade_lvl = 4'd8;
    build_expected(400, 300, 10, 20, 2, 4'd8);
    base = wr_count;
    spr_mark = base + NPIX;
    run_frame("A", 1'b1, cyc);
    check("A_spr_writes", wr_count - base - NPIX, 128);
    check("A_first_spr_addr", first_spr_addr, 4810);
    check("A_first_spr_data", first_spr_data, EXP_WHITE);
    check("A_pix00", fb_mem[0], fadepix(24'd77040 ^ salt, 4'd8));
    check("A_oob", oob_count, 0);
    check_frame("A_frame", NPIX);
    snap = wr_count;
    repeat (10) @(posedge clk); #1;
    check("A_idle_no_we", wr_count - snap, 0);

    // Frame R: origin camera, aborted by reset (with start asserted) at cycle 1000
    salt = pixel_t'($urandom);
    fill_sprites(100);
    camX = '0; camY = '0;
    s_px = int'($urandom_range(0, 255)); s_py = int'($urandom_range(0, 255)); s_dir = int'($urandom_range(0, 3));
    playerX = 8'(s_px); playerY = 8'(s_py); playerDir = 2'(s_dir); fade_lvl = 4'($urandom);
    build_expected(0, 0, s_px, s_py, s_dir, fade_lvl);
    spr_mark = -1;
    base = wr_count;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (999) @(posedge clk); #1;
    Reset = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    check("R_we", bus.FBwe, 0);
    check("R_busy", busy, 0);
    check("R_done", done, 0);
    check("R_map_addr", bus.mapAddr, 0);
    snap = wr_count;
    check("R_partial_writes", snap - base, R_WRITES);
    Reset = 1'b1;
    start = 1'b0;
    repeat (20) @(posedge clk); #1;
    check("R_busy_after", busy, 0);
    check("R_no_writes_after", wr_count - snap, 0);
    check_frame("R_origin_pixels", 900);

    // Frame B: random camera, sprite clipped at the bottom-right corner
    salt = pixel_t'($urandom);
    fill_sprites(25);
    s_dir = int'($urandom_range(0, 3));
    camX = 9'($urandom); camY = 9'($urandom);
    playerX = 8'd232; playerY = 8'd152; playerDir = 2'(s_dir); fade_lvl = 4'd0;
    build_expected(int'(camX), int'(camY), 232, 152, s_dir, 4'd0);
    base = wr_count;
    snap = oob_count;
    run_frame("B", 1'b0, cyc);
    check("B_writes", wr_count - base, NPIX + exp_spr);
    check("B_oob", oob_count - snap, 0);
    check_frame("B_frame", NPIX);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fb_blitter.md
Name: fb_blitter

Overview:
- Frame composer that fills the 240x160x24-bit framebuffer RAM consumed by the VGA 2x-upscale display stage.
- On each start pulse it copies a 240x160 camera window of the world-map ROM into the framebuffer, then overlays the 16x16 player sprite with colour-key transparency.
- It is the sole writer of the framebuffer write port (FBwrite_address / FBdata_In / FBwe).

Parameters:
- MAP_W, 480, world-map width in pixels
- MAP_H, 320, world-map height in pixels
- KEY_COLOR, 24'hFF00FF, transparent sprite colour; never written
- FB_W, 240, framebuffer width (fixed for the display stage)
- FB_H, 160, framebuffer height (fixed)

Ports:
- Clk  in  1  system clock; all logic on posedge
- Reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to compose a frame (driven at vertical blank)
- camX  in  9  map x of framebuffer pixel (0,0)
- camY  in  9  map y of framebuffer pixel (0,0)
- playerX  in  8  sprite top-left x in framebuffer coordinates
- playerY  in  8  sprite top-left y in framebuffer coordinates
- playerDir  in  2  sprite frame: 0 down, 1 up, 2 left, 3 right
- mapAddr  out  19  map ROM read address
- mapData  in  24  map ROM data; synchronous, 1-cycle read latency
- sprAddr  out  10  sprite ROM address = {playerDir, row[3:0], col[3:0]}
- sprData  in  24  sprite ROM data; 1-cycle read latency
- FBwrite_address  out  19  framebuffer write address = y*240 + x
- FBdata_In  out  24  framebuffer write data, {R,G,B}
- FBwe  out  1  framebuffer write enable
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the frame is complete

Behaviour:
- Reset (Reset==0 at a posedge): state IDLE; counters 0; FBwe=0, FBwrite_address=0, FBdata_In=0, busy=0, done=0, mapAddr=0, sprAddr=0. Reset mid-frame aborts immediately and performs no further writes.
- States: IDLE -> DRAW_MAP -> DRAW_CHAR -> FINISH -> IDLE.
- IDLE:
  - start=1 latches camX/camY/playerX/playerY/playerDir; next state DRAW_MAP with x=y=0.
  - Inputs are not resampled until the next frame.
- DRAW_MAP:
  - Raster order: x increments 0..239, then y increments; 38400 reads.
  - mapAddr = (camYc+y)*MAP_W + (camXc+x), with camXc=min(camX, MAP_W-240) and camYc=min(camY, MAP_H-160), computed at 19 bits without overflow.
  - Pipeline: read issued in cycle k, ROM data in k+1, registered write (FBwe=1) visible in cycle k+2.
- DRAW_CHAR:
  - Entered once the last map read has been issued; 256 sprite reads in raster order.
  - Write target is (playerX+col, playerY+row), computed at 9 bits.
  - Write suppressed (FBwe=0) when sprData==KEY_COLOR, target x>239, or target y>159 (clipping, no wrap).
  - Same 2-cycle read-to-write latency. Pending map writes drain in order; at most one write per cycle.
- FINISH:
  - Waits for the pipeline to empty.
  - done=1 for exactly one cycle, in the cycle after the final write slot; busy drops in that same cycle; then IDLE.
- start while busy=1 is ignored; no queueing.
- start coincident with Reset==0: reset wins.
- Total cost: start accepted at edge E0 gives done high in cycle E0+38400+256+3.
- FBwe is never high in IDLE.

Optional Feature:
- Macro: FB_BLITTER_FADE_EN.
- With the macro: adds input port fade[3:0], latched at start. Every written channel becomes (c*(15-fade))>>4, using 8-bit x 4-bit multiplies with the result truncated to 8 bits. Key-colour test uses the raw sprData. Adds one pipeline stage, so read-to-write latency is 3 and done is 1 cycle later.
- Without the macro: no fade port; data is written unmodified.

Decomposition:
- Package fb_pkg:
  - FB_W=240, FB_H=160, FB_ADDR_W=19
  - blit_state_t enum {IDLE, DRAW_MAP, DRAW_CHAR, FINISH}
  - pixel_t (24-bit RGB) typedef
  - DIR_DOWN/UP/LEFT/RIGHT constants
- One sub-module, fb_write_pipe: registers the write valid/address/data, applies the key/clip suppression, and holds the optional fade stage.

Test Plan:
- Map copy, origin camera: map ROM model data=address; camX=camY=0, sprite fully keyed. Expect framebuffer address a = y*240+x to hold y*480+x, and exactly 38400 writes.
- Camera clamp: camX=400, camY=300. Expect the window clamped to (240,160); pixel (0,0) = map(240,160) = 160*480+240 = 77040.
- Transparency and direction: playerDir=2, playerX=10, playerY=20, checkerboard key sprite. Expect exactly 128 sprite writes, starting with FB address 20*240+10=4810 carrying the correct frame data.
- Clipping: playerX=232, playerY=152. Expect only the 8x8 in-bounds quadrant written (64 writes); no address >=38400.
- Control: start during busy is ignored. Reset low at cycle 1000 gives FBwe=0, busy=0 next cycle. A fresh start then gives done after exactly 38659 cycles (38660 with FB_BLITTER_FADE_EN).
- Fade (macro on): fade=8, pixel 8'hFF gives (255*7)>>4 = 8'h6F; fade=0 gives 8'hEF.
